// File: rtl/cube_pkg.sv
// Shared cube geometry, scan FSM encodings and cell addressing.
// The cube simulator and the display driver both import this package.
package cube_pkg;

   localparam int CUBE_DIM   = 8;
   localparam int CUBE_CELLS = CUBE_DIM * CUBE_DIM * CUBE_DIM;
   localparam int LAYER_BITS = CUBE_DIM * CUBE_DIM;
   localparam int COORD_W    = $clog2(CUBE_DIM);
   localparam int CELL_W     = $clog2(CUBE_CELLS);

   typedef enum logic [1:0] {
      ST_BLANK = 2'd0,
      ST_SHIFT = 2'd1,
      ST_LATCH = 2'd2,
      ST_ON    = 2'd3
   } scan_state_t;

   // y selects the display layer; x and z address a cell within it
   function automatic logic [CELL_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y,
                                                  input logic [COORD_W-1:0] z);
      return CELL_W'(x) + CELL_W'(y) * CELL_W'(CUBE_DIM) + CELL_W'(z) * CELL_W'(CUBE_DIM * CUBE_DIM);
   endfunction

endpackage

// File: rtl/cube_shift_out.sv
// Serialises one 64-bit layer word MSB first onto a 595-style chain.
// Each bit spends CLK_DIV clocks with the shift clock low, then CLK_DIV high.
module cube_shift_out
   import cube_pkg::*;
#(
   parameter int CLK_DIV = 2
)
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  i_load,
   input  logic [LAYER_BITS-1:0] i_bits,
   output logic                  o_ser_data,
   output logic                  o_ser_clk,
   output logic                  o_done
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(LAYER_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LAYER_BITS - 1);

   logic [LAYER_BITS-1:0] r_sr;
   logic [DIV_W-1:0]      r_div;
   logic [BIT_W-1:0]      r_bit;
   logic                  r_clk;
   logic                  r_busy;
   logic                  w_half_end;

   assign w_half_end = r_busy && (r_div == DIV_LAST);
   // done coincides with the last clock of the final high half-period
   assign o_done     = w_half_end && r_clk && (r_bit == BIT_LAST);
   assign o_ser_data = r_busy & r_sr[LAYER_BITS-1];
   assign o_ser_clk  = r_clk;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sr   <= '0;
         r_div  <= '0;
         r_bit  <= '0;
         r_clk  <= 1'b0;
         r_busy <= 1'b0;
      end else if (i_load) begin
         r_sr   <= i_bits;
         r_div  <= '0;
         r_bit  <= '0;
         r_clk  <= 1'b0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         if (w_half_end) begin
            r_div <= '0;
            r_clk <= ~r_clk;
            if (r_clk) begin
               if (r_bit == BIT_LAST) begin
                  r_busy <= 1'b0;
               end else begin
                  r_bit <= r_bit + 1'b1;
                  r_sr  <= {r_sr[LAYER_BITS-2:0], 1'b0};
               end
            end
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cube_scan_driver.sv
// Multiplexes the 8x8x8 LED cube one layer at a time from a per-refresh
// snapshot of the cell frame, feeding column data through a serial chain.
module cube_scan_driver
   import cube_pkg::*;
#(
   parameter int CLK_DIV      = 2,
   parameter int ON_CYCLES    = 1000,
   parameter int BLANK_CYCLES = 8
)
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [CUBE_CELLS-1:0] Cells,
   input  logic                  Enable,
   output logic                  ser_data,
   output logic                  ser_clk,
   output logic                  ser_latch,
   output logic                  ser_oe_n,
   output logic [CUBE_DIM-1:0]   layer_en,
   output logic [COORD_W-1:0]    cur_layer,
   output logic                  frame_start
);

   localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES)
                          ? ((ON_CYCLES > CLK_DIV) ? ON_CYCLES : CLK_DIV)
                          : ((BLANK_CYCLES > CLK_DIV) ? BLANK_CYCLES : CLK_DIV);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);

   scan_state_t             r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [COORD_W-1:0]      r_layer;
   logic [CUBE_CELLS-1:0]   r_frame_buf;
   logic                    r_snap_pending;
   logic                    r_frame_start;

   scan_state_t             w_state_next;
   logic [CNT_W-1:0]        w_cnt_next;
   logic [COORD_W-1:0]      w_layer_next;
   logic                    w_pending_next;
   logic                    w_snap;
   logic                    w_load;
   logic                    w_done;
   logic [CUBE_CELLS-1:0]   w_src;
   logic [LAYER_BITS-1:0]   w_bits;

   // a snapshot and a shifter load can share one edge, so gather from Cells then
   assign w_snap = (r_state == ST_BLANK) && r_snap_pending && Enable;
   assign w_src  = w_snap ? Cells : r_frame_buf;

   for (genvar gi = 0; gi < LAYER_BITS; gi++) begin : g_gather
      assign w_bits[gi] = w_src[cell_idx(COORD_W'(gi % CUBE_DIM), r_layer,
                                         COORD_W'(gi / CUBE_DIM))];
   end

   cube_shift_out #(
      .CLK_DIV (CLK_DIV)
   ) u_shift (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_load     (w_load),
      .i_bits     (w_bits),
      .o_ser_data (ser_data),
      .o_ser_clk  (ser_clk),
      .o_done     (w_done)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state        <= ST_BLANK;
         r_cnt          <= '0;
         r_layer        <= '0;
         r_frame_buf    <= '0;
         r_snap_pending <= 1'b1;
         r_frame_start  <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_cnt          <= w_cnt_next;
         r_layer        <= w_layer_next;
         r_snap_pending <= w_pending_next;
         r_frame_start  <= w_snap;
         if (w_snap) begin
            r_frame_buf <= Cells;
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_layer_next   = r_layer;
      w_pending_next = r_snap_pending && !w_snap;
      w_load         = 1'b0;
      ser_latch      = 1'b0;
      ser_oe_n       = 1'b1;
      layer_en       = '0;
      case (r_state)
         ST_BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               if (Enable) begin
                  w_state_next = ST_SHIFT;
                  w_cnt_next   = '0;
                  w_load       = 1'b1;
               end else if (r_layer == '0) begin
                  // holding before layer 0: refresh the frame once scanning resumes
                  w_pending_next = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (w_done) begin
               w_state_next = ST_LATCH;
               w_cnt_next   = '0;
            end
         end
         ST_LATCH: begin
            ser_latch = 1'b1;
            if (r_cnt == LATCH_LAST) begin
               w_state_next = ST_ON;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         ST_ON: begin
            ser_oe_n = 1'b0;
            layer_en = CUBE_DIM'(1) << r_layer;
            if (r_cnt == ON_LAST) begin
               w_state_next = ST_BLANK;
               w_cnt_next   = '0;
               w_layer_next = r_layer + 1'b1;
               if (r_layer == COORD_W'(CUBE_DIM - 1)) begin
                  w_pending_next = 1'b1;
               end
            end else begin
               w_cnt_next = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_BLANK;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign cur_layer   = r_layer;
   assign frame_start = r_frame_start;

endmodule
